// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver states and
// the FIFO entry layout.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Entries always carry 8 data bits; narrower frames are zero-extended.
    localparam int MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rx_state_e;

    typedef struct packed {
        logic                     parity_err;
        logic                     frame_err;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO. The head is visible whenever the FIFO
// is non-empty; when empty the last popped word is presented so the read
// side holds steady instead of exposing stale storage.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    // Storage array, written without reset (read path is masked while empty).
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and the hold register for the empty case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// Oversampling UART receiver: synchronises the line, centres sampling on
// each bit via a half-bit start delay, checks parity/stop and queues each
// frame with its error flags in a show-ahead FIFO.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_parity_err_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          rx_overflow_o,
    input  logic                          clr_err_i,
    output logic                          rx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_e            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frame_err_q;
    logic                 stop_hi_q;
    logic                 tick;
    logic                 last_stop;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 fifo_empty;
    logic                 fifo_full;
    rx_entry_t            push_entry;
    rx_entry_t            head;

    assign tick      = (baud_cnt == '0);
    assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));
    assign push      = (state == STOP) && tick && last_stop;
    assign pop       = rx_valid_o && rx_ready_i;
    assign drop      = push && fifo_full && !pop;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM with baud counter; the final stop sample itself is folded
    // into the pushed entry so the write lands on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop_hi_q   <= 1'b0;
        end else begin
            if (state != IDLE && state != BRK)
                baud_cnt <= tick ? FULL_RELOAD : baud_cnt - 1'b1;
            unique case (state)
                IDLE: if (!rxs) begin
                    state       <= START;
                    baud_cnt    <= HALF_RELOAD;
                    bit_cnt     <= '0;
                    par_err_q   <= 1'b0;
                    frame_err_q <= 1'b0;
                    stop_hi_q   <= 1'b0;
                end
                START: if (tick) state <= rxs ? IDLE : DATA;
                DATA: if (tick) begin
                    shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    par_err_q <= ((^shreg) ^ rxs) != (PARITY_MODE == PARITY_ODD);
                    state     <= STOP;
                end
                STOP: if (tick) begin
                    if (!rxs) frame_err_q <= 1'b1;
                    else      stop_hi_q   <= 1'b1;
                    if (last_stop)
                        state <= (shreg == '0 && !stop_hi_q && !rxs) ? BRK : IDLE;
                    else
                        bit_cnt <= bit_cnt + 1'b1;
                end
                BRK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Entry assembled from the current stop sample plus accumulated flags.
    always_comb begin
        push_entry                      = '0;
        push_entry.parity_err           = par_err_q;
        push_entry.frame_err            = frame_err_q | ~rxs;
        push_entry.data[DATA_BITS-1:0]  = shreg;
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rx_overflow_o <= 1'b0;
        else if (drop)      rx_overflow_o <= 1'b1;
        else if (clr_err_i) rx_overflow_o <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count_o)
    );

    assign rx_valid_o      = !fifo_empty;
    assign rx_data_o       = head.data[DATA_BITS-1:0];
    assign rx_frame_err_o  = head.frame_err;
    assign rx_parity_err_o = head.parity_err;
    assign rx_busy_o       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench: three receivers (8N1, 8E1, 8O1) at 16 clk/bit. Stimulus
// queues expected {parity_err, frame_err, data} entries; monitors pop and
// compare whenever a receiver hands over an entry.
module tb_uart_rx_capture;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main 8N1 receiver
    logic       rx0, ready0, clr0;
    logic [7:0] data0;
    logic       fe0, pe0, valid0, ovf0, busy0;
    logic [4:0] cnt0;
    // Parity receivers share one line
    logic       rx_p;
    logic       ready_p;
    logic [7:0] data_e, data_o;
    logic       fe_e, pe_e, valid_e, ovf_e, busy_e;
    logic       fe_o, pe_o, valid_o, ovf_o, busy_o;
    logic [4:0] cnt_e, cnt_o;
    logic       clr_p;

    int n_vec = 0;
    int n_err = 0;
    int vhi0  = 0;
    logic [9:0] q0[$];
    logic [9:0] qe[$];
    logic [9:0] qo[$];

    uart_rx_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx0), .rx_data_o(data0),
        .rx_frame_err_o(fe0), .rx_parity_err_o(pe0), .rx_valid_o(valid0),
        .rx_ready_i(ready0), .rx_overflow_o(ovf0), .clr_err_i(clr0),
        .rx_busy_o(busy0), .fifo_count_o(cnt0));

    uart_rx_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .rx_data_o(data_e),
        .rx_frame_err_o(fe_e), .rx_parity_err_o(pe_e), .rx_valid_o(valid_e),
        .rx_ready_i(ready_p), .rx_overflow_o(ovf_e), .clr_err_i(clr_p),
        .rx_busy_o(busy_e), .fifo_count_o(cnt_e));

    uart_rx_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .rx_data_o(data_o),
        .rx_frame_err_o(fe_o), .rx_parity_err_o(pe_o), .rx_valid_o(valid_o),
        .rx_ready_i(ready_p), .rx_overflow_o(ovf_o), .clr_err_i(clr_p),
        .rx_busy_o(busy_o), .fifo_count_o(cnt_o));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [9:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got entry %0h, none expected", name, act);
    endtask

    task automatic drive(input bit on_p, input logic v);
        if (on_p) rx_p = v;
        else      rx0  = v;
    endtask

    // Called at a negedge; start bit is driven immediately. par < 0: no parity bit.
    task automatic send_frame(input logic [7:0] d, input int par, input logic stopv, input bit on_p);
        drive(on_p, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(on_p, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (par >= 0) begin
            drive(on_p, par[0]);
            repeat (CPB) @(negedge clk);
        end
        drive(on_p, stopv);
        repeat (CPB) @(negedge clk);
        drive(on_p, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (q0.size() + qe.size() + qo.size()) != 0; i++)
            @(negedge clk);
        check(name, 32'(q0.size() + qe.size() + qo.size()), 32'd0);
    endtask

    // Monitors sample just after the negedge, when inputs have settled.
    always @(negedge clk) begin
        #1;
        if (valid0) vhi0++;
        if (valid0 && ready0) begin
            if (q0.size() == 0) unexpected("main_pop", {pe0, fe0, data0});
            else check("main_pop", 32'({pe0, fe0, data0}), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        #1;
        if (valid_e && ready_p) begin
            if (qe.size() == 0) unexpected("even_pop", {pe_e, fe_e, data_e});
            else check("even_pop", 32'({pe_e, fe_e, data_e}), 32'(qe.pop_front()));
        end
    end

    always @(negedge clk) begin
        #1;
        if (valid_o && ready_p) begin
            if (qo.size() == 0) unexpected("odd_pop", {pe_o, fe_o, data_o});
            else check("odd_pop", 32'({pe_o, fe_o, data_o}), 32'(qo.pop_front()));
        end
    end

    initial begin
        int v0;
        rst_n = 1'b0; rx0 = 1'b1; rx_p = 1'b1;
        ready0 = 1'b1; ready_p = 1'b1; clr0 = 1'b0; clr_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_ovf",   32'(ovf0), 32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_data",  32'({pe0, fe0, data0}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 8N1 frame
        q0.push_back({2'b00, 8'h55});
        v0 = vhi0;
        send_frame(8'h55, -1, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("valid_pulse_width", 32'(vhi0 - v0), 32'd1);
        check("busy_after_stop", 32'(busy0), 32'd0);

        // Stop bit low
        q0.push_back({2'b01, 8'hA3});
        send_frame(8'hA3, -1, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        check("busy_after_frame_err", 32'(busy0), 32'd0);

        // Break: 40 bit-times low
        q0.push_back({2'b01, 8'h00});
        rx0 = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        check("busy_in_break", 32'(busy0), 32'd1);
        check("count_in_break", 32'(cnt0), 32'd0);
        rx0 = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_break", 32'(busy0), 32'd0);

        // Start glitch
        rx0 = 1'b0;
        repeat (6) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_count", 32'(cnt0), 32'd0);
        check("glitch_busy", 32'(busy0), 32'd0);

        // Parity: 0x07 has odd popcount
        qe.push_back({2'b10, 8'h07});
        qo.push_back({2'b00, 8'h07});
        send_frame(8'h07, 0, 1'b1, 1'b1);
        qe.push_back({2'b00, 8'h07});
        qo.push_back({2'b10, 8'h07});
        send_frame(8'h07, 1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        wait_drain("parity_drain");

        // Overflow: 17 back-to-back frames, consumer stalled
        ready0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q0.push_back({2'b00, 8'(8'h10 + i)});
            send_frame(8'(8'h10 + i), -1, 1'b1, 1'b0);
        end
        repeat (20) @(negedge clk);
        check("ovf_count", 32'(cnt0), 32'd16);
        check("ovf_flag", 32'(ovf0), 32'd1);
        check("ovf_head", 32'(data0), 32'h10);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(ovf0), 32'd0);
        ready0 = 1'b1;
        wait_drain("ovf_drain");

        // Full FIFO: 17th frame's push coincides with a pop
        ready0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            q0.push_back({2'b00, 8'(8'h20 + i)});
            send_frame(8'(8'h20 + i), -1, 1'b1, 1'b0);
        end
        q0.push_back({2'b00, 8'h30});
        fork
            send_frame(8'h30, -1, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge clk);
                ready0 = 1'b1;
                @(negedge clk);
                ready0 = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("pushpop_count", 32'(cnt0), 32'd16);
        check("pushpop_ovf", 32'(ovf0), 32'd0);
        ready0 = 1'b1;
        wait_drain("pushpop_drain");

        // Reset mid-frame with entries held
        ready0 = 1'b0;
        send_frame(8'h61, -1, 1'b1, 1'b0);
        send_frame(8'h62, -1, 1'b1, 1'b0);
        rx0 = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_count", 32'(cnt0), 32'd0);
        check("midreset_valid", 32'(valid0), 32'd0);
        check("midreset_busy", 32'(busy0), 32'd0);
        ready0 = 1'b1;
        repeat (5) @(negedge clk);
        wait_drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
